// File: rtl/packet_rx_if.sv
// ---------------------------------------------------------------------------
// packet_rx_if -- word stream into the receiver and decoded packet out of it.
//
// Handshake: rxValid qualifies rxWord for exactly one clock per word; there is
// no ready/back-pressure, so the receiver must take or drop every word on the
// cycle it is offered. pktValid / pktError are one-cycle strobes from the
// receiver and are never high together. The f* fields and iAmDestination are
// level outputs that hold between accepted packets.
//
// Modports:
//   slave  : the receiver (consumes rxWord/rxValid, drives packet outputs)
//   master : the radio/testbench side (drives words, observes packet outputs)
// ---------------------------------------------------------------------------
interface packet_rx_if;
  logic [15:0] rxWord;
  logic        rxValid;

  logic [2:0]  fPacketType;
  logic [15:0] fSourceID;
  logic [15:0] fSourceHops;
  logic [15:0] fQValue;
  logic [15:0] fEnergyLeft;
  logic [15:0] fDestinationID;
  logic [15:0] fChosenCH;
  logic [15:0] fHopsFromCH;
  logic        iAmDestination;
  logic        pktValid;
  logic        pktError;

  modport slave (
    input  rxWord, rxValid,
    output fPacketType, fSourceID, fSourceHops, fQValue, fEnergyLeft,
           fDestinationID, fChosenCH, fHopsFromCH, iAmDestination,
           pktValid, pktError
  );

  modport master (
    output rxWord, rxValid,
    input  fPacketType, fSourceID, fSourceHops, fQValue, fEnergyLeft,
           fDestinationID, fChosenCH, fHopsFromCH, iAmDestination,
           pktValid, pktError
  );
endinterface

// File: rtl/packet_rx.sv
// ---------------------------------------------------------------------------
// packet_rx -- receives a fixed-length packet from the radio one 16-bit word
// at a time, checks it, and publishes the decoded fields.
//
// Packet layout: w0[15:13] type (w0[12:0] ignored), then source ID, source
// hops, Q-value, energy left, destination ID, chosen CH, hops from CH.
// Types 3'b000..3'b100 are accepted; 3'b101..3'b111 are dropped.
//
// Optional feature (macro PKT_RX_CHECKSUM_EN): the packet grows to nine words,
// w8 = XOR of w0..w7; a mismatch drops the packet. Without the macro there is
// no checksum logic at all.
//
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   en        : receive enable, only looked at while IDLE
//   myNodeID  : this node's ID for destination matching (0xFFFF = broadcast)
//   busy      : high in every state except IDLE
//   state_dbg : current FSM state (IDLE=0, RECV=1, CHECK=2, DONE=3)
//   pkt       : packet_rx_if.slave (word input, field outputs, strobes)
//
// Timing: the word w7 (or w8) is sampled at edge E0 (-> CHECK), the fields
// and pktValid are registered at E1 (-> DONE), i.e. pktValid appears two
// cycles after the cycle carrying the last word. A silent gap of 16 cycles
// inside a packet aborts it with pktError.
// ---------------------------------------------------------------------------
module packet_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] myNodeID,
  output logic        busy,
  output logic [1:0]  state_dbg,
  packet_rx_if.slave  pkt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

`ifdef PKT_RX_CHECKSUM_EN
  localparam int NUM_WORDS = 9;
`else
  localparam int NUM_WORDS = 8;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);
  localparam logic [3:0] GAP_LIMIT = 4'd15;

  logic [1:0]  state;
  logic [3:0]  word_cnt;
  logic [3:0]  gap_cnt;
  logic [2:0]  type_q;
  // Shadow copies of w1..w(last); w0 only keeps what is actually needed.
  logic [15:0] body_q [1:NUM_WORDS-1];

  logic        type_bad;
  logic        drop;
  logic        dest_match;

`ifdef PKT_RX_CHECKSUM_EN
  logic [12:0] w0_low_q;
  logic [15:0] chk_calc;
  logic        chk_ok;

  always_comb begin
    chk_calc = {type_q, w0_low_q};
    for (int i = 1; i < NUM_WORDS - 1; i++) begin
      chk_calc = chk_calc ^ body_q[i];
    end
    chk_ok = (chk_calc == body_q[NUM_WORDS-1]);
  end
`endif

  // 3'b101, 3'b110, 3'b111 are the reserved types.
  assign type_bad   = type_q[2] & (type_q[1] | type_q[0]);
`ifdef PKT_RX_CHECKSUM_EN
  assign drop       = type_bad | ~chk_ok;
`else
  assign drop       = type_bad;
`endif
  // Full 16-bit compare against w5; broadcast is all-ones.
  assign dest_match = (body_q[5] == myNodeID) || (body_q[5] == 16'hFFFF);

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= 4'd0;
      gap_cnt  <= 4'd0;
      type_q   <= 3'd0;
      for (int i = 1; i < NUM_WORDS; i++) begin
        body_q[i] <= 16'd0;
      end
`ifdef PKT_RX_CHECKSUM_EN
      w0_low_q <= 13'd0;
`endif
      pkt.fPacketType    <= 3'b111;
      pkt.fSourceID      <= 16'hFFFF;
      pkt.fSourceHops    <= 16'hFFFF;
      pkt.fQValue        <= 16'h0000;
      pkt.fEnergyLeft    <= 16'h0000;
      pkt.fDestinationID <= 16'h0000;
      pkt.fChosenCH      <= 16'h0000;
      pkt.fHopsFromCH    <= 16'hFFFF;
      pkt.iAmDestination <= 1'b0;
      pkt.pktValid       <= 1'b0;
      pkt.pktError       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      pkt.pktValid <= 1'b0;
      pkt.pktError <= 1'b0;

      case (state)
        IDLE: begin
          if (en && pkt.rxValid) begin
            type_q   <= pkt.rxWord[15:13];
`ifdef PKT_RX_CHECKSUM_EN
            w0_low_q <= pkt.rxWord[12:0];
`endif
            word_cnt <= 4'd1;
            gap_cnt  <= 4'd0;
            state    <= RECV;
          end
        end

        RECV: begin
          if (pkt.rxValid) begin
            for (int i = 1; i < NUM_WORDS; i++) begin
              if (word_cnt == 4'(i)) begin
                body_q[i] <= pkt.rxWord;
              end
            end
            word_cnt <= word_cnt + 4'd1;
            gap_cnt  <= 4'd0;
            if (word_cnt == LAST_IDX) begin
              state <= CHECK;
            end
          end else if (gap_cnt == GAP_LIMIT) begin
            // This is the 16th consecutive silent cycle: give up.
            pkt.pktError <= 1'b1;
            gap_cnt      <= 4'd0;
            word_cnt     <= 4'd0;
            state        <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        CHECK: begin
          if (drop) begin
            pkt.pktError <= 1'b1;
            state        <= IDLE;
          end else begin
            pkt.fPacketType    <= type_q;
            pkt.fSourceID      <= body_q[1];
            pkt.fSourceHops    <= body_q[2];
            pkt.fQValue        <= body_q[3];
            pkt.fEnergyLeft    <= body_q[4];
            pkt.fDestinationID <= body_q[5];
            pkt.fChosenCH      <= body_q[6];
            pkt.fHopsFromCH    <= body_q[7];
            pkt.iAmDestination <= dest_match;
            pkt.pktValid       <= 1'b1;
            state              <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_rx.sv
// ---------------------------------------------------------------------------
// tb_packet_rx -- directed testbench for packet_rx.
// Expected field values are written by hand from the packet words; a
// negedge monitor feeds every pktValid through the expected queue.
// ---------------------------------------------------------------------------
module tb_packet_rx;

  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] myNodeID;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  packet_rx_if pkt_bus ();

  packet_rx dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .myNodeID  (myNodeID),
    .busy      (busy),
    .state_dbg (state_dbg),
    .pkt       (pkt_bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [15:0]  last_chk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [2:0] t, input logic [15:0] s,
                                        input logic [15:0] h, input logic [15:0] q,
                                        input logic [15:0] e, input logic [15:0] d,
                                        input logic [15:0] c, input logic [15:0] hf,
                                        input logic iad);
    return {12'd0, t, s, h, q, e, d, c, hf, iad};
  endfunction

  function automatic logic [W-1:0] cur_fields();
    return pack(pkt_bus.fPacketType, pkt_bus.fSourceID, pkt_bus.fSourceHops,
                pkt_bus.fQValue, pkt_bus.fEnergyLeft, pkt_bus.fDestinationID,
                pkt_bus.fChosenCH, pkt_bus.fHopsFromCH, pkt_bus.iAmDestination);
  endfunction

  function automatic logic [7:0][15:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                          input logic [15:0] w2, input logic [15:0] w3,
                                          input logic [15:0] w4, input logic [15:0] w5,
                                          input logic [15:0] w6, input logic [15:0] w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  // Monitor: strobe exclusivity and field check on every accepted packet.
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_bus.pktValid || pkt_bus.pktError) begin
        check("strobe_excl", W'(pkt_bus.pktValid & pkt_bus.pktError), W'(0));
      end
      if (pkt_bus.pktError) err_cnt++;
      if (pkt_bus.pktValid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_valid", W'(1), W'(0));
        end else begin
          check("sb_fields", cur_fields(), exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pkt_bus.rxWord = 16'($urandom_range(0, 65535));
      tick();
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    pkt_bus.rxWord  = w;
    pkt_bus.rxValid = 1'b1;
    tick();
    pkt_bus.rxValid = 1'b0;
    pkt_bus.rxWord  = 16'($urandom_range(0, 65535));
  endtask

  // Sends words 0..nwords-1; optional idle gap after word gap_at; en drops
  // after word en_off_at; a full packet gets a checksum word when enabled.
  task automatic send_pkt(input logic [7:0][15:0] w, input int nwords, input int gap_at,
                          input int gap_len, input int en_off_at, input bit bad_chk);
    logic [15:0] x;
    logic [15:0] chk_word;
    x = 16'd0;
    for (int i = 0; i < nwords; i++) begin
      send_word(w[i]);
      x = x ^ w[i];
      if (i == en_off_at) en = 1'b0;
      if (i == gap_at) idle(gap_len);
    end
    chk_word = bad_chk ? (x ^ 16'h0010) : x;
`ifdef PKT_RX_CHECKSUM_EN
    if (nwords == 8) send_word(chk_word);
`else
    last_chk = chk_word;
`endif
  endtask

  // Called right after the last word's edge (cycle 1). Waits for a strobe and
  // checks its kind and the cycle it arrived in.
  task automatic wait_strobe(input string tag, input bit exp_valid, input int exp_lat);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (pkt_bus.pktValid || pkt_bus.pktError) begin
        seen = 1'b1;
        lat = i;
        break;
      end
      tick();
    end
    check({tag, "_seen"}, W'(seen), W'(1));
    check({tag, "_valid"}, W'(pkt_bus.pktValid), W'(exp_valid));
    check({tag, "_error"}, W'(pkt_bus.pktError), W'(!exp_valid));
    check({tag, "_lat"}, W'(lat), W'(exp_lat));
  endtask

  task automatic expect_pkt(input logic [W-1:0] e);
    exp_q.push_back(e);
    last_exp = e;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] rst_val;
  logic [7:0][15:0] p_hb, p_uni, p_me, p_part, p_t2, p_gap, p_tmo, p_bad;
  logic [W-1:0] e_hb, e_uni, e_me, e_part, e_t2, e_gap;
  logic [15:0] bad_types [3];
  int v0, e0;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_val = pack(3'b111, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b0);
    p_hb   = mk(16'h0000, 16'h0000, 16'h0003, 16'h3555, 16'h7FFC, 16'hFFFF, 16'h0000, 16'hFFFF);
    e_hb   = pack(3'b000, 16'h0000, 16'h0003, 16'h3555, 16'h7FFC, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1);
    p_uni  = mk(16'h4000, 16'd23, 16'h0001, 16'h1234, 16'h0800, 16'h0011, 16'h0005, 16'h0002);
    e_uni  = pack(3'b010, 16'd23, 16'h0001, 16'h1234, 16'h0800, 16'h0011, 16'h0005, 16'h0002, 1'b0);
    p_me   = mk(16'h9FFF, 16'h0021, 16'h0002, 16'h00AA, 16'h0100, 16'h000C, 16'h0021, 16'h0000);
    e_me   = pack(3'b100, 16'h0021, 16'h0002, 16'h00AA, 16'h0100, 16'h000C, 16'h0021, 16'h0000, 1'b1);
    p_part = mk(16'h2000, 16'h0005, 16'h0003, 16'h0BCD, 16'h0200, 16'h800C, 16'h0009, 16'h0001);
    e_part = pack(3'b001, 16'h0005, 16'h0003, 16'h0BCD, 16'h0200, 16'h800C, 16'h0009, 16'h0001, 1'b0);
    p_t2   = mk(16'h6123, 16'h0042, 16'h0004, 16'h0F0F, 16'h0400, 16'hFFFF, 16'h0042, 16'h0003);
    e_t2   = pack(3'b011, 16'h0042, 16'h0004, 16'h0F0F, 16'h0400, 16'hFFFF, 16'h0042, 16'h0003, 1'b1);
    p_gap  = mk(16'h8000, 16'h0007, 16'h0001, 16'h0001, 16'h0002, 16'h000D, 16'h0007, 16'h0001);
    e_gap  = pack(3'b100, 16'h0007, 16'h0001, 16'h0001, 16'h0002, 16'h000D, 16'h0007, 16'h0001, 1'b0);
    p_tmo  = mk(16'h6000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
    bad_types[0] = 16'hA000;
    bad_types[1] = 16'hC000;
    bad_types[2] = 16'hE000;

    rst = 1'b1;
    en = 1'b0;
    myNodeID = 16'h000C;
    pkt_bus.rxValid = 1'b0;
    pkt_bus.rxWord = 16'h0;
    last_chk = 16'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_fields", cur_fields(), rst_val);
    check("rst_valid", W'(pkt_bus.pktValid), W'(0));
    check("rst_error", W'(pkt_bus.pktError), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_state", W'(state_dbg), W'(0));
    rst = 1'b0;
    en = 1'b1;
    last_exp = rst_val;

    // Heartbeat, back to back, first edge after reset release takes w0
    expect_pkt(e_hb);
    send_pkt(p_hb, 8, -1, 0, -1, 1'b0);
    check("hb_state_check", W'(state_dbg), W'(2));
    check("hb_busy", W'(busy), W'(1));
    wait_strobe("hb", 1'b1, 2);
    tick();
    check("hb_pulse_len", W'(pkt_bus.pktValid), W'(0));
    check("hb_idle_after", W'(busy), W'(0));
    check("hb_hold", cur_fields(), e_hb);

    // Unicast to another node
    expect_pkt(e_uni);
    send_pkt(p_uni, 8, -1, 0, -1, 1'b0);
    wait_strobe("uni", 1'b1, 2);
    tick();

    // Unicast to me (w0 low bits ignored), then one-bit partial match
    expect_pkt(e_me);
    send_pkt(p_me, 8, -1, 0, -1, 1'b0);
    wait_strobe("me", 1'b1, 2);
    tick();
    expect_pkt(e_part);
    send_pkt(p_part, 8, -1, 0, -1, 1'b0);
    wait_strobe("part", 1'b1, 2);
    tick();

    // Reserved types are dropped and leave fields alone
    for (int k = 0; k < 3; k++) begin
      p_bad = mk(bad_types[k], 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h000C, 16'h1212, 16'h3434);
      v0 = valid_cnt;
      send_pkt(p_bad, 8, -1, 0, -1, 1'b0);
      wait_strobe($sformatf("badtype%0d", k), 1'b0, 2);
      tick();
      check($sformatf("badtype%0d_hold", k), cur_fields(), last_exp);
      check($sformatf("badtype%0d_novalid", k), W'(valid_cnt - v0), W'(0));
    end

    // Timeout after w3
    send_pkt(p_tmo, 4, -1, 0, -1, 1'b0);
    check("tmo_busy_during", W'(busy), W'(1));
    check("tmo_state_recv", W'(state_dbg), W'(1));
    wait_strobe("tmo", 1'b0, 17);
    check("tmo_busy_after", W'(busy), W'(0));
    check("tmo_hold", cur_fields(), last_exp);
    tick();
    expect_pkt(e_t2);
    send_pkt(p_t2, 8, -1, 0, -1, 1'b0);
    wait_strobe("tmo_next", 1'b1, 2);
    tick();

    // A 15-cycle gap is still tolerated
    expect_pkt(e_gap);
    send_pkt(p_gap, 8, 2, 15, -1, 1'b0);
    wait_strobe("gap15", 1'b1, 2);
    tick();

    // en low in IDLE: packet is ignored entirely
    en = 1'b0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_pkt(p_uni, 8, -1, 0, -1, 1'b0);
    idle(3);
    check("en_off_busy", W'(busy), W'(0));
    check("en_off_nostrobe", W'((valid_cnt - v0) + (err_cnt - e0)), W'(0));
    en = 1'b1;

    // en dropped after w0 does not disturb the packet
    expect_pkt(e_uni);
    send_pkt(p_uni, 8, -1, 0, 0, 1'b0);
    wait_strobe("en_drop", 1'b1, 2);
    tick();
    en = 1'b1;

    // rxValid during CHECK and DONE is ignored
    expect_pkt(e_me);
    send_pkt(p_me, 8, -1, 0, -1, 1'b0);
    pkt_bus.rxWord = 16'h5A5A;
    pkt_bus.rxValid = 1'b1;
    tick();
    check("ign_valid", W'(pkt_bus.pktValid), W'(1));
    tick();
    pkt_bus.rxValid = 1'b0;
    check("ign_idle", W'(busy), W'(0));
    check("ign_hold", cur_fields(), e_me);
    tick();
    check("ign_still_idle", W'(busy), W'(0));

`ifdef PKT_RX_CHECKSUM_EN
    // Checksum word with one bit flipped
    v0 = valid_cnt;
    send_pkt(p_hb, 8, -1, 0, -1, 1'b1);
    wait_strobe("badchk", 1'b0, 2);
    tick();
    check("badchk_hold", cur_fields(), last_exp);
    check("badchk_novalid", W'(valid_cnt - v0), W'(0));
`endif

    // Reset in the middle of a packet
    v0 = valid_cnt;
    e0 = err_cnt;
    send_pkt(p_t2, 5, -1, 0, -1, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_state", W'(state_dbg), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_fields", cur_fields(), rst_val);
    check("midrst_valid", W'(pkt_bus.pktValid), W'(0));
    check("midrst_error", W'(pkt_bus.pktError), W'(0));
    rst = 1'b0;
    last_exp = rst_val;
    expect_pkt(e_hb);
    send_pkt(p_hb, 8, -1, 0, -1, 1'b0);
    wait_strobe("after_rst", 1'b1, 2);
    tick();
    check("midrst_no_error", W'(err_cnt - e0), W'(0));
    check("midrst_one_valid", W'(valid_cnt - v0), W'(1));

    idle(2);
    check("sb_queue_empty", W'(exp_q.size()), W'(0));
    check("unused_chk_word_seen", W'(last_chk !== 16'hxxxx), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_rx.md
PACKET_RX -- requirements
Module: packet_rx

Interface
REQ-001 The block SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-003 The block SHALL have en, input, 1, a receive enable sampled only in IDLE.
REQ-004 The block SHALL have rxWord, input, 16, the incoming packet word from the radio.
REQ-005 The block SHALL have rxValid, input, 1, which qualifies rxWord for one cycle per word.
REQ-006 The block SHALL have myNodeID, input, 16, this node's ID, used for destination matching.
REQ-007 The block SHALL have these field outputs: fPacketType (3), fSourceID, fSourceHops, fQValue, fEnergyLeft, fDestinationID, fChosenCH and fHopsFromCH (16 each).
REQ-008 The block SHALL have iAmDestination, output, 1, set when the destination is myNodeID or 16'hFFFF.
REQ-009 The block SHALL have pktValid, output, 1, a one-cycle accepted-packet strobe.
REQ-010 The block SHALL have pktError, output, 1, a one-cycle dropped-packet strobe.
REQ-011 The block SHALL have busy, output, 1, high in every state except IDLE.

Function
REQ-012 The packet SHALL be eight words, in this order:
- w0: bits [15:13] are the type; bits [12:0] are ignored.
- w1 to w7: source ID, source hops, Q-value, energy left, destination ID, chosen CH, hops from CH.
REQ-013 The FSM states SHALL be IDLE, RECV, CHECK and DONE.
REQ-014 IDLE SHALL move to RECV only when en and rxValid are both high; that word SHALL be captured as w0 and the word counter set to 1.
REQ-015 In RECV, each rxValid SHALL capture one word into a shadow register and increment the 4-bit counter; after the last word the FSM SHALL go to CHECK.
REQ-016 In RECV, a gap counter SHALL count cycles without rxValid and clear on every rxValid; on reaching 16 it SHALL abort to IDLE with pktError pulsed.
REQ-017 In CHECK, a type of 3'b101, 3'b110 or 3'b111 SHALL drop the packet (pktError, then IDLE); types 3'b000 to 3'b100 SHALL pass to DONE.
REQ-018 On entry to DONE, all f* outputs and iAmDestination SHALL be loaded from the shadow registers in a single cycle, and pktValid SHALL be high for exactly that cycle.
REQ-019 DONE SHALL return to IDLE on the next cycle, giving latency from the last word to pktValid of 2 cycles.
REQ-020 The f* outputs SHALL hold their values until the next accepted packet; dropped packets SHALL never alter them.
REQ-021 rxValid in CHECK or DONE SHALL be ignored, and the word SHALL be lost.
REQ-022 A change of en after leaving IDLE SHALL NOT affect the packet in progress.
REQ-023 pktValid and pktError SHALL never be high in the same cycle.
REQ-024 iAmDestination SHALL compare all 16 bits of w5; no partial match SHALL be allowed.

Reset
REQ-025 rst SHALL override all other inputs and force IDLE, including in the middle of a packet.
REQ-026 rst SHALL clear the word counter and gap counter and discard the shadow registers.
REQ-027 Reset output values SHALL be:
- fPacketType = 3'b111; fSourceID, fSourceHops, fHopsFromCH = 16'hFFFF.
- fQValue, fEnergyLeft, fDestinationID, fChosenCH = 0.
- iAmDestination, pktValid, pktError, busy = 0.
REQ-028 The first rising edge after rst deasserts SHALL be able to accept w0.

Configuration
REQ-029 With macro PKT_RX_CHECKSUM_EN defined, the packet SHALL be nine words, w8 being the XOR of w0 to w7.
REQ-030 With PKT_RX_CHECKSUM_EN defined, a checksum mismatch in CHECK SHALL drop the packet with pktError, and the type check SHALL still apply.
REQ-031 Without PKT_RX_CHECKSUM_EN, the packet SHALL be eight words with no checksum logic and no checksum register.

Verification
REQ-032 Heartbeat: en=1, myNodeID=16'h000C, words 16'h0000,16'h0000,16'h0003,16'h3555,16'h7FFC,16'hFFFF,16'h0000,16'hFFFF sent back to back -> pktValid 2 cycles after w7, fPacketType=3'b000, fSourceHops=3, fQValue=16'h3555, iAmDestination=1.
REQ-033 Unicast to another node: type 3'b010, source 16'd23, destination 16'h0011 -> pktValid=1, iAmDestination=0, fSourceID=16'd23.
REQ-034 Invalid type: w0=16'hE000 -> pktError pulses once, pktValid stays 0, all f* keep their prior values.
REQ-035 Timeout: stop after w3 and idle for 16 cycles -> pktError, busy=0; the next full packet is accepted correctly.
REQ-036 Reset: assert rst after w4 -> IDLE next cycle, outputs at reset values, no strobe; a following packet is accepted.
REQ-037 With PKT_RX_CHECKSUM_EN: a correct w8 -> pktValid; w8 with one bit flipped -> pktError and outputs unchanged.
